hf_tag_manchester_decoder: RTL and testbench

HF_TAG_MANCHESTER_DECODER -- requirements
Module: hf_tag_manchester_decoder

---
 rtl/hf_tag_manchester_decoder.sv | 175 +++++++++++++++++
 tb/tb_hf_tag_manchester_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hf_tag_manchester_decoder.sv
// rtl/hf_tag_manchester_decoder.sv - Manchester subcarrier bit decoder for the HF tag receive path
module hf_tag_manchester_decoder #(
    parameter int HALF_THRESH = 2
) (
    input  logic       osc_clk,
    input  logic       nreset,
    input  logic       enable,
    input  logic       slot_stb,
    input  logic       curbit,
    output logic [7:0] data_out,
    output logic [3:0] data_nbits,
    output logic       parity_ok,
    output logic       data_valid,
    output logic       sof,
    output logic       eof,
    output logic       coll_err,
    output logic       frame_active
);

    typedef enum logic [1:0] {S_IDLE, S_SOF, S_DATA} state_e;
    typedef enum logic [1:0] {B_ZERO, B_ONE, B_NONE, B_COLL} bit_cls_e;

    localparam logic [2:0] THR = 3'(HALF_THRESH);

    state_e     state_q;
    logic [2:0] slot_q;
    logic [2:0] cnt1_q;
    logic [2:0] cnt2_q;
    logic [3:0] bit_cnt_q;
    logic [8:0] shreg_q;
    logic [7:0] data_out_q;
    logic [3:0] data_nbits_q;
    logic       parity_ok_q;
    logic       data_valid_q;
    logic       sof_q;
    logic       eof_q;
    logic       coll_err_q;
    logic       frame_active_q;

    logic [2:0] cnt1_d;
    logic [2:0] cnt2_d;
    logic [8:0] shreg_d;
    bit_cls_e   cls;

    // The slot-7 sample still has to be folded into the second half before classifying.
    always_comb begin
        cnt1_d = cnt1_q + {2'b00, curbit};
        cnt2_d = cnt2_q + {2'b00, curbit};
        cls    = B_NONE;
        if ((cnt1_q >= THR) && (cnt2_d >= THR)) begin
            cls = B_COLL;
        end else if (cnt1_q >= THR) begin
            cls = B_ONE;
        end else if (cnt2_d >= THR) begin
            cls = B_ZERO;
        end
        shreg_d            = shreg_q;
        shreg_d[bit_cnt_q] = (cls == B_ONE);
    end

    always_ff @(negedge osc_clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= S_IDLE;
            slot_q         <= 3'd0;
            cnt1_q         <= 3'd0;
            cnt2_q         <= 3'd0;
            bit_cnt_q      <= 4'd0;
            shreg_q        <= 9'd0;
            data_out_q     <= 8'd0;
            data_nbits_q   <= 4'd0;
            parity_ok_q    <= 1'b0;
            data_valid_q   <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            coll_err_q     <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            coll_err_q   <= 1'b0;
            if (!enable) begin
                state_q        <= S_IDLE;
                slot_q         <= 3'd0;
                cnt1_q         <= 3'd0;
                cnt2_q         <= 3'd0;
                bit_cnt_q      <= 4'd0;
                shreg_q        <= 9'd0;
                frame_active_q <= 1'b0;
            end else if (slot_stb) begin
                case (state_q)
                    S_IDLE: begin
                        if (curbit) begin
                            state_q <= S_SOF;
                            slot_q  <= 3'd1;
                            cnt1_q  <= 3'd1;
                            cnt2_q  <= 3'd0;
                        end
                    end
                    default: begin
                        if (slot_q != 3'd7) begin
                            slot_q <= slot_q + 3'd1;
                            if (slot_q[2]) begin
                                cnt2_q <= cnt2_d;
                            end else begin
                                cnt1_q <= cnt1_d;
                            end
                        end else begin
                            slot_q <= 3'd0;
                            cnt1_q <= 3'd0;
                            cnt2_q <= 3'd0;
                            if (state_q == S_SOF) begin
                                if (cls == B_ONE) begin
                                    sof_q          <= 1'b1;
                                    frame_active_q <= 1'b1;
                                    state_q        <= S_DATA;
                                    bit_cnt_q      <= 4'd0;
                                    shreg_q        <= 9'd0;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                case (cls)
                                    B_ZERO, B_ONE: begin
                                        if (bit_cnt_q == 4'd8) begin
                                            data_valid_q <= 1'b1;
                                            data_out_q   <= shreg_q[7:0];
                                            data_nbits_q <= 4'd8;
                                            parity_ok_q  <= ^shreg_d;
                                            bit_cnt_q    <= 4'd0;
                                            shreg_q      <= 9'd0;
                                        end else begin
                                            shreg_q   <= shreg_d;
                                            bit_cnt_q <= bit_cnt_q + 4'd1;
                                        end
                                    end
                                    B_NONE: begin
                                        eof_q          <= 1'b1;
                                        frame_active_q <= 1'b0;
                                        state_q        <= S_IDLE;
                                        if (bit_cnt_q != 4'd0) begin
                                            data_valid_q <= 1'b1;
                                            data_out_q   <= shreg_q[7:0];
                                            data_nbits_q <= bit_cnt_q;
                                            parity_ok_q  <= 1'b0;
                                        end
                                        bit_cnt_q <= 4'd0;
                                        shreg_q   <= 9'd0;
                                    end
                                    default: begin
                                        coll_err_q     <= 1'b1;
                                        frame_active_q <= 1'b0;
                                        state_q        <= S_IDLE;
                                        bit_cnt_q      <= 4'd0;
                                        shreg_q        <= 9'd0;
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign data_out     = data_out_q;
    assign data_nbits   = data_nbits_q;
    assign parity_ok    = parity_ok_q;
    assign data_valid   = data_valid_q;
    assign sof          = sof_q;
    assign eof          = eof_q;
    assign coll_err     = coll_err_q;
    assign frame_active = frame_active_q;

endmodule

// File: tb/tb_hf_tag_manchester_decoder.sv
// tb/tb_hf_tag_manchester_decoder.sv - randomized frame-level bench for hf_tag_manchester_decoder
module tb_hf_tag_manchester_decoder;

    localparam int THR = 2;
    localparam int C0  = 0;
    localparam int C1  = 1;
    localparam int CN  = 2;
    localparam int CC  = 3;

    logic       osc_clk = 1'b0;
    logic       nreset  = 1'b0;
    logic       enable  = 1'b0;
    logic       slot_stb = 1'b0;
    logic       curbit  = 1'b0;
    logic [7:0] data_out;
    logic [3:0] data_nbits;
    logic       parity_ok;
    logic       data_valid;
    logic       sof;
    logic       eof;
    logic       coll_err;
    logic       frame_active;

    int total = 0;
    int bad   = 0;
    int stray = 0;
    int held  = 0;
    int frame_bits[$];

    hf_tag_manchester_decoder #(.HALF_THRESH(THR)) dut (
        .osc_clk      (osc_clk),
        .nreset       (nreset),
        .enable       (enable),
        .slot_stb     (slot_stb),
        .curbit       (curbit),
        .data_out     (data_out),
        .data_nbits   (data_nbits),
        .parity_ok    (parity_ok),
        .data_valid   (data_valid),
        .sof          (sof),
        .eof          (eof),
        .coll_err     (coll_err),
        .frame_active (frame_active)
    );

    always #37 osc_clk = ~osc_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] make_half(input logic modulated);
        logic [3:0] h;
        int k;
        h = 4'b0000;
        k = modulated ? int'($urandom_range(4, THR)) : int'($urandom_range(THR - 1, 0));
        while ($countones(h) < k) h[$urandom_range(3, 0)] = 1'b1;
        return h;
    endfunction

    // Slot s of a bit is pattern bit s; slots 0-3 form the first half.
    function automatic logic [7:0] make_pat(input int cls, input logic force_slot0);
        logic [3:0] a;
        logic [3:0] b;
        a = make_half(cls == C1 || cls == CC);
        b = make_half(cls == C0 || cls == CC);
        if (force_slot0) a[0] = 1'b1;
        return {b, a};
    endfunction

    function automatic int pack_bits(input int base, input int n);
        int v;
        v = 0;
        for (int j = 0; j < n; j++) v = v | (frame_bits[base + j] << j);
        return v;
    endfunction

    task automatic send_slot(input logic b, output logic [3:0] p);
        @(posedge osc_clk);
        slot_stb = 1'b1;
        curbit   = b;
        @(posedge osc_clk);
        slot_stb = 1'b0;
        curbit   = 1'($urandom);
        p = {sof, eof, data_valid, coll_err};
        repeat (14) begin
            @(posedge osc_clk);
            if (sof | eof | data_valid | coll_err) stray++;
        end
    endtask

    task automatic send_bit(input logic [7:0] pat, output logic [3:0] pv);
        logic [3:0] p;
        for (int s = 0; s < 8; s++) begin
            send_slot(pat[s], p);
            if (s != 7 && p != 4'b0000) stray++;
        end
        pv = p;
    endtask

    task automatic run_frame(input string nm, input int term, input logic [7:0] tpat);
        logic [3:0] pv;
        logic [3:0] e;
        int n;
        int rem;
        int byte_v;
        int par;
        n     = frame_bits.size();
        stray = 0;
        send_bit(make_pat(C1, 1'b1), pv);
        check({nm, "_sof"}, 32'(pv), 32'(4'b1000));
        check({nm, "_active"}, 32'(frame_active), 32'd1);
        for (int i = 0; i < n; i++) begin
            send_bit(make_pat(frame_bits[i], 1'b0), pv);
            if ((i % 9) == 8) begin
                byte_v = pack_bits(i - 8, 8);
                par    = $countones(pack_bits(i - 8, 9)) % 2;
                check({nm, "_byte_pulse"}, 32'(pv), 32'(4'b0010));
                check({nm, "_byte_data"}, 32'(data_out), 32'(byte_v));
                check({nm, "_byte_nbits"}, 32'(data_nbits), 32'd8);
                check({nm, "_byte_parity"}, 32'(parity_ok), 32'(par));
                held = byte_v;
            end else begin
                check({nm, "_bit_quiet"}, 32'(pv), 32'd0);
            end
        end
        rem = n % 9;
        send_bit(tpat, pv);
        if (term == CN) begin
            e = 4'b0100;
            if (rem != 0) e[1] = 1'b1;
            check({nm, "_eof_pulse"}, 32'(pv), 32'(e));
            if (rem != 0) begin
                held = pack_bits(n - rem, rem);
                check({nm, "_tail_nbits"}, 32'(data_nbits), 32'(rem));
                check({nm, "_tail_parity"}, 32'(parity_ok), 32'd0);
            end
        end else begin
            check({nm, "_coll_pulse"}, 32'(pv), 32'(4'b0001));
        end
        check({nm, "_data_out"}, 32'(data_out), 32'(held));
        check({nm, "_inactive"}, 32'(frame_active), 32'd0);
        check({nm, "_stray"}, 32'(stray), 32'd0);
    endtask

    initial begin
        logic [3:0] pv;
        logic [3:0] acc;
        int n;
        int term;

        repeat (3) @(posedge osc_clk);
        check("reset_outputs", 32'({data_out, data_nbits, parity_ok, data_valid, sof, eof, coll_err, frame_active}), 32'd0);
        nreset = 1'b1;
        enable = 1'b1;
        send_bit(8'h00, pv);
        check("idle_quiet", 32'(pv), 32'd0);

        frame_bits = '{0, 1, 1, 0, 0, 1, 0};
        run_frame("reqa", CN, make_pat(CN, 1'b0));
        check("reqa_value", 32'(data_out), 32'h26);

        frame_bits = '{1, 1, 0, 0, 1, 0, 0, 1, 0};
        run_frame("p0", CN, make_pat(CN, 1'b0));

        frame_bits = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
        run_frame("p1", CN, make_pat(CN, 1'b0));

        frame_bits = '{1, 0};
        run_frame("coll", CC, 8'b0111_0111);

        frame_bits = '{1, 0, 1};
        run_frame("weak", CN, 8'b0100_0010);

        stray = 0;
        send_bit(8'b0000_0001, pv);
        check("glitch_nosof", 32'(pv), 32'd0);
        check("glitch_inactive", 32'(frame_active), 32'd0);
        check("glitch_stray", 32'(stray), 32'd0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(20, 0);
            frame_bits.delete();
            for (int i = 0; i < n; i++) frame_bits.push_back(int'($urandom_range(1, 0)));
            term = ($urandom_range(3, 0) == 0) ? CC : CN;
            run_frame("rand", term, make_pat(term, 1'b0));
        end

        frame_bits = '{1, 1, 0, 0, 1, 0, 0, 1, 1};
        run_frame("pre_rst", CN, make_pat(CN, 1'b0));
        send_bit(make_pat(C1, 1'b1), pv);
        for (int i = 0; i < 4; i++) send_bit(make_pat(int'($urandom_range(1, 0)), 1'b0), pv);
        for (int s = 0; s < 3; s++) send_slot(1'($urandom), pv);
        @(posedge osc_clk);
        #3 nreset = 1'b0;
        #1 check("midrst_outputs", 32'({data_out, data_nbits, parity_ok, data_valid, sof, eof, coll_err, frame_active}), 32'd0);
        @(posedge osc_clk);
        nreset = 1'b1;
        held = 0;
        frame_bits = '{0, 1, 0, 0, 1, 0, 1, 0};
        run_frame("f52", CN, make_pat(CN, 1'b0));
        check("f52_value", 32'(data_out), 32'h52);

        send_bit(make_pat(C1, 1'b1), pv);
        for (int i = 0; i < 3; i++) send_bit(make_pat(int'($urandom_range(1, 0)), 1'b0), pv);
        @(posedge osc_clk);
        enable = 1'b0;
        stray  = 0;
        acc    = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            send_bit(make_pat(i == 5 ? CN : int'($urandom_range(1, 0)), 1'b0), pv);
            acc = acc | pv;
        end
        check("dis_pulses", 32'(acc), 32'd0);
        check("dis_stray", 32'(stray), 32'd0);
        check("dis_inactive", 32'(frame_active), 32'd0);
        check("dis_hold", 32'(data_out), 32'(held));
        enable = 1'b1;
        send_bit(8'h00, pv);
        frame_bits = '{0, 1, 1, 0, 0, 1, 0};
        run_frame("reqa2", CN, make_pat(CN, 1'b0));
        check("reqa2_value", 32'(data_out), 32'h26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
